// File: rtl/ff_readback.sv
// ff_readback: snapshots four wide register fields on request and streams them out as
// BEAT-wide beats over a valid/ready channel, field 1 first, LSB first.
// Build option: define FF_READBACK_CHECKSUM_EN to append one XOR-checksum beat per frame.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   snap_req            one-cycle pulse: capture {d4,d3,d2,d1} and start a frame (IDLE only)
//   d1..d4              field values to capture (d1 least significant)
//   busy                high while a frame is being streamed
//   out_valid/out_ready beat handshake; out_data/out_last held stable while stalled
//   out_data, out_last  beat payload and end-of-frame marker
//   drop_cnt            saturating count of snap_req pulses ignored while busy
module ff_readback #(
   parameter int W1   = 64,
   parameter int W2   = 32,
   parameter int W3   = 8,
   parameter int W4   = 80,
   parameter int BEAT = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            snap_req,
   input  logic [W1-1:0]   d1,
   input  logic [W2-1:0]   d2,
   input  logic [W3-1:0]   d3,
   input  logic [W4-1:0]   d4,
   output logic            busy,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [BEAT-1:0] out_data,
   output logic            out_last,
   output logic [7:0]      drop_cnt
);

   localparam int TOTAL = W1 + W2 + W3 + W4;
   localparam int NB    = TOTAL / BEAT;
`ifdef FF_READBACK_CHECKSUM_EN
   localparam int NBT   = NB + 1;
`else
   localparam int NBT   = NB;
`endif
   // Sized for NB+1 so the checksum beat index still fits when enabled.
   localparam int IW    = $clog2(NB + 1);
   localparam logic [IW-1:0] LAST_IDX = IW'(NBT - 1);

   generate
      if (TOTAL % BEAT != 0) begin : g_bad_beat
         $error("ff_readback: W1+W2+W3+W4 must be a multiple of BEAT");
      end
   endgenerate

   typedef enum logic {IDLE, SEND} state_t;

   state_t           state, state_nxt;
   logic [TOTAL-1:0] snap;
   logic [IW-1:0]    idx;
   logic [BEAT-1:0]  beat_sel;
   logic             at_last;

   assign at_last = (idx == LAST_IDX);

   // Beat mux written as a compare loop to keep the slice index constant.
   always_comb begin
      beat_sel = '0;
      for (int k = 0; k < NB; k++) begin
         if (idx == IW'(k)) beat_sel = snap[k*BEAT +: BEAT];
      end
`ifdef FF_READBACK_CHECKSUM_EN
      if (idx == IW'(NB)) begin
         for (int k = 0; k < NB; k++) begin
            beat_sel = beat_sel ^ snap[k*BEAT +: BEAT];
         end
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      out_valid = 1'b0;
      out_last  = 1'b0;
      out_data  = '0;
      case (state)
         IDLE: begin
            if (snap_req) state_nxt = SEND;
         end
         SEND: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            out_last  = at_last;
            out_data  = beat_sel;
            if (out_ready && at_last) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Snapshot contents are only meaningful in SEND, so they are left out of reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         idx <= '0;
      end else if (state == IDLE && snap_req) begin
         snap <= {d4, d3, d2, d1};
         idx  <= '0;
      end else if (state == SEND && out_ready) begin
         idx <= at_last ? '0 : idx + 1'b1;
      end
   end

   // Any request seen in SEND is dropped, including the final-handshake cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         drop_cnt <= 8'd0;
      end else if (state == SEND && snap_req && drop_cnt != 8'hFF) begin
         drop_cnt <= drop_cnt + 8'd1;
      end
   end

endmodule

// File: tb/tb_ff_readback.sv
module tb_ff_readback;

   localparam int TOTAL = 184;
   localparam int NB    = 23;
`ifdef FF_READBACK_CHECKSUM_EN
   localparam int NBT   = NB + 1;
`else
   localparam int NBT   = NB;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        snap_req;
   logic [63:0] d1;
   logic [31:0] d2;
   logic [7:0]  d3;
   logic [79:0] d4;
   logic        busy;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  out_data;
   logic        out_last;
   logic [7:0]  drop_cnt;

   ff_readback dut (
      .clk      (clk),
      .rst      (rst),
      .snap_req (snap_req),
      .d1       (d1),
      .d2       (d2),
      .d3       (d3),
      .d4       (d4),
      .busy     (busy),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data (out_data),
      .out_last (out_last),
      .drop_cnt (drop_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] d;
      logic       l;
   } beat_t;

   beat_t q[$];
   int    n_chk  = 0;
   int    n_fail = 0;
   logic  bp_mode = 1'b0;
   logic [3:0] pat = 4'b1001;

   localparam logic [63:0] B1 = 64'h0706050403020100;
   localparam logic [31:0] B2 = 32'h0B0A0908;
   localparam logic [7:0]  B3 = 8'h0C;
   localparam logic [79:0] B4 = 80'h16151413121110_0F0E0D;

   task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_frame(input logic [TOTAL-1:0] v);
      beat_t      b;
      logic [7:0] x;
      x = 8'h00;
      for (int k = 0; k < NB; k++) begin
         b.d = v[k*8 +: 8];
         b.l = (k == NBT - 1);
         x   = x ^ b.d;
         q.push_back(b);
      end
`ifdef FF_READBACK_CHECKSUM_EN
      b.d = x;
      b.l = 1'b1;
      q.push_back(b);
`endif
   endtask

   task automatic set_basic();
      d1 = B1; d2 = B2; d3 = B3; d4 = B4;
   endtask

   // Pulse snap_req from IDLE and expect the first beat on the next cycle.
   task automatic start_frame();
      snap_req = 1'b1;
      push_frame({d4, d3, d2, d1});
      tick();
      snap_req = 1'b0;
      check("first_valid", out_valid, 1);
      check("first_busy", busy, 1);
   endtask

   task automatic wait_done();
      for (int i = 0; i < 400; i++) begin
         if (q.size() == 0) break;
         tick();
      end
      check("frame_done", q.size() == 0, 1);
      q.delete();
      check("idle_valid", out_valid, 0);
      check("idle_busy", busy, 0);
   endtask

   // Scoreboard: every valid beat must match the head of the queue; pop on handshake.
   always @(negedge clk) begin
      if (!rst && out_valid) begin
         if (q.size() == 0) begin
            check("extra_beat", 1, 0);
         end else begin
            check("beat_data", out_data, q[0].d);
            check("beat_last", out_last, q[0].l);
            if (out_ready) void'(q.pop_front());
         end
      end
   end

   initial begin
      int cyc;
      cyc = 0;
      out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         out_ready = bp_mode ? pat[cyc % 4] : 1'b1;
         cyc++;
      end
   end

   initial begin
      rst = 1'b1; snap_req = 1'b0;
      d1 = '0; d2 = '0; d3 = '0; d4 = '0;
      tick();
      tick();
      check("rst_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_last", out_last, 0);
      check("rst_data", out_data, 0);
      check("rst_drop", drop_cnt, 0);
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         check("idle_no_valid", out_valid, 0);
      end

      // Basic frame, ready always high.
      set_basic();
      start_frame();
      wait_done();

      // Backpressure with ready pattern 1,0,0,1.
      tick();
      bp_mode = 1'b1;
      start_frame();
      wait_done();
      bp_mode = 1'b0;
      tick();
      tick();

      // Random data under backpressure.
      d1 = {$urandom, $urandom};
      d2 = $urandom;
      d3 = 8'($urandom);
      d4 = 80'({$urandom, $urandom, $urandom});
      bp_mode = 1'b1;
      start_frame();
      wait_done();
      bp_mode = 1'b0;
      tick();
      tick();

      // Drops: one at beat 5, one on the final handshake, then accepted in first IDLE cycle.
      set_basic();
      start_frame();
      repeat (5) tick();
      snap_req = 1'b1;
      tick();
      snap_req = 1'b0;
      repeat (NBT - 7) tick();
      check("drop_at_last", out_last, 1);
      snap_req = 1'b1;
      tick();
      check("drop_gap_busy", busy, 0);
      push_frame({d4, d3, d2, d1});
      tick();
      snap_req = 1'b0;
      check("drop_cnt", drop_cnt, 2);
      check("reaccept_valid", out_valid, 1);
      wait_done();
      tick();

      // Snapshot isolation: inputs change right after the request.
      start_frame();
      d1 = '1; d2 = '1; d3 = '1; d4 = '1;
      wait_done();
      set_basic();
      tick();

      // Reset mid-frame at beat 10, then a clean full frame.
      start_frame();
      repeat (10) tick();
      rst = 1'b1;
      q.delete();
      tick();
      rst = 1'b0;
      check("midrst_valid", out_valid, 0);
      check("midrst_busy", busy, 0);
      check("midrst_last", out_last, 0);
      check("midrst_drop", drop_cnt, 0);
      tick();
      start_frame();
      wait_done();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
